sync_fifo_flags: RTL and testbench

//  Single-clock FIFO with occupancy count, programmable almost-full/almost-empty flags,

---
 rtl/sync_fifo_flags.sv | 83 ++++++++
 tb/tb_sync_fifo_flags.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with level, almost flags, optional FWFT read port, flush and sticky errors.
module sync_fifo_flags #(
    parameter int Width             = 8,
    parameter int Size              = 8,
    parameter bit FallThrough       = 1'b0,
    parameter int AlmostFullThresh  = Size - 1,
    parameter int AlmostEmptyThresh = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      write_req_i,
    output logic                      write_valid_o,
    input  logic [Width-1:0]          data_i,
    input  logic                      read_req_i,
    output logic                      read_valid_o,
    output logic [Width-1:0]          data_o,
    output logic [$clog2(Size+1)-1:0] level_o,
    output logic                      almost_full_o,
    output logic                      almost_empty_o,
    output logic                      overflow_o,
    output logic                      underflow_o
);
    localparam int LW = $clog2(Size + 1);
    localparam int PW = $clog2(Size);

    if (Size < 2) begin : g_bad_size
        $error("sync_fifo_flags: Size must be >= 2");
    end
    if (AlmostFullThresh < 1 || AlmostFullThresh > Size) begin : g_bad_af
        $error("sync_fifo_flags: AlmostFullThresh out of range 1..Size");
    end
    if (AlmostEmptyThresh < 0 || AlmostEmptyThresh > Size - 1) begin : g_bad_ae
        $error("sync_fifo_flags: AlmostEmptyThresh out of range 0..Size-1");
    end

    logic [Width-1:0] mem [Size];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [Width-1:0] data_q;
    logic             wr_hs, rd_hs;

    // Pointers wrap explicitly so depth need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(Size - 1)) ? '0 : p + 1'b1;
    endfunction

    assign write_valid_o  = level_o != LW'(Size);
    assign read_valid_o   = level_o != '0;
    assign wr_hs          = write_req_i & write_valid_o;
    assign rd_hs          = read_req_i & read_valid_o;
    assign almost_full_o  = level_o >= LW'(AlmostFullThresh);
    assign almost_empty_o = level_o <= LW'(AlmostEmptyThresh);
    assign data_o         = FallThrough ? (read_valid_o ? mem[rd_ptr] : '0) : data_q;

    always_ff @(posedge clk_i) begin
        if (wr_hs && !flush_i && !rst_i) mem[wr_ptr] <= data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_o     <= '0;
            data_q      <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (write_req_i && !write_valid_o) overflow_o <= 1'b1;
            if (read_req_i && !read_valid_o) underflow_o <= 1'b1;
            if (flush_i) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                level_o <= '0;
            end else begin
                if (wr_hs) wr_ptr <= next_ptr(wr_ptr);
                if (rd_hs) rd_ptr <= next_ptr(rd_ptr);
                level_o <= (wr_hs && !rd_hs) ? level_o + 1'b1 :
                           (rd_hs && !wr_hs) ? level_o - 1'b1 : level_o;
                if (rd_hs && !FallThrough) data_q <= mem[rd_ptr];
            end
        end
    end
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: two FIFO configurations (registered Size=8, FWFT Size=5) against a list-based model.
module tb_sync_fifo_flags;
    logic       clk = 1'b0;
    logic       rst, flush, wreq, rreq;
    logic [7:0] din;

    logic       a_wv, a_rv, a_af, a_ae, a_ov, a_un;
    logic [7:0] a_dout;
    logic [3:0] a_level;
    logic       b_wv, b_rv, b_af, b_ae, b_ov, b_un;
    logic [7:0] b_dout;
    logic [2:0] b_level;

    int total = 0;
    int bad   = 0;

    int         sz [2] = '{8, 5};
    bit         ft [2] = '{1'b0, 1'b1};
    int         af [2] = '{7, 3};
    int         ae [2] = '{1, 2};
    logic [7:0] mq [2][8];
    int         cnt [2];
    bit         ovf [2];
    bit         unf [2];
    logic [7:0] dq [2];

    always #5 clk = ~clk;

    sync_fifo_flags #(.Width(8), .Size(8), .FallThrough(1'b0)) u_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .write_req_i(wreq), .write_valid_o(a_wv),
        .data_i(din), .read_req_i(rreq), .read_valid_o(a_rv), .data_o(a_dout), .level_o(a_level),
        .almost_full_o(a_af), .almost_empty_o(a_ae), .overflow_o(a_ov), .underflow_o(a_un));

    sync_fifo_flags #(.Width(8), .Size(5), .FallThrough(1'b1), .AlmostFullThresh(3),
                      .AlmostEmptyThresh(2)) u_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .write_req_i(wreq), .write_valid_o(b_wv),
        .data_i(din), .read_req_i(rreq), .read_valid_o(b_rv), .data_o(b_dout), .level_o(b_level),
        .almost_full_o(b_af), .almost_empty_o(b_ae), .overflow_o(b_ov), .underflow_o(b_un));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_one(input int k, input logic [3:0] lvl, input logic wv, input logic rv,
                             input logic f_af, input logic f_ae, input logic ov, input logic un,
                             input logic [7:0] dout);
        string n = (k == 0) ? "a" : "b";
        logic [7:0] exp_d = ft[k] ? ((cnt[k] != 0) ? mq[k][0] : 8'h00) : dq[k];
        chk({n, " level"}, 32'(lvl), 32'(cnt[k]));
        chk({n, " write_valid"}, 32'(wv), 32'(cnt[k] != sz[k]));
        chk({n, " read_valid"}, 32'(rv), 32'(cnt[k] != 0));
        chk({n, " almost_full"}, 32'(f_af), 32'(cnt[k] >= af[k]));
        chk({n, " almost_empty"}, 32'(f_ae), 32'(cnt[k] <= ae[k]));
        chk({n, " overflow"}, 32'(ov), 32'(ovf[k]));
        chk({n, " underflow"}, 32'(un), 32'(unf[k]));
        chk({n, " data"}, 32'(dout), 32'(exp_d));
    endtask

    task automatic step(input logic r, input logic f, input logic w, input logic rd, input logic [7:0] d);
        rst = r; flush = f; wreq = w; rreq = rd; din = d;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            bit wv = cnt[k] != sz[k];
            bit rv = cnt[k] != 0;
            if (r) begin
                cnt[k] = 0; ovf[k] = 0; unf[k] = 0; dq[k] = 8'h00;
            end else begin
                if (w && !wv) ovf[k] = 1;
                if (rd && !rv) unf[k] = 1;
                if (f) cnt[k] = 0;
                else begin
                    if (rd && rv) begin
                        if (!ft[k]) dq[k] = mq[k][0];
                        for (int i = 0; i < 7; i++) mq[k][i] = mq[k][i+1];
                        cnt[k]--;
                    end
                    if (w && wv) begin
                        mq[k][cnt[k]] = d;
                        cnt[k]++;
                    end
                end
            end
        end
        @(negedge clk);
        check_one(0, a_level, a_wv, a_rv, a_af, a_ae, a_ov, a_un, a_dout);
        check_one(1, {1'b0, b_level}, b_wv, b_rv, b_af, b_ae, b_ov, b_un, b_dout);
    endtask

    initial begin
        int bias;
        rst = 1'b1; flush = 1'b0; wreq = 1'b0; rreq = 1'b0; din = 8'h00;
        cnt = '{0, 0}; ovf = '{0, 0}; unf = '{0, 0}; dq = '{8'h00, 8'h00};
        step(1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 8'h00);
        chk("reset a level", 32'(a_level), 0);
        chk("reset a write_valid", 32'(a_wv), 1);
        chk("reset a almost_empty", 32'(a_ae), 1);
        // FWFT head visible the cycle after the write, before any pop
        step(0, 0, 1, 0, 8'hA5);
        chk("b fwft head", 32'(b_dout), 32'h0A5);
        chk("b fwft read_valid", 32'(b_rv), 1);
        step(0, 0, 0, 1, 8'h00);
        chk("a popped A5", 32'(a_dout), 32'h0A5);
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 1, 0, 8'(i));
            if (i == 7) chk("a almost_full at 7", 32'(a_af), 1);
        end
        chk("a full level", 32'(a_level), 8);
        chk("a full write_valid", 32'(a_wv), 0);
        step(0, 0, 1, 1, 8'hEE);
        chk("a full rw level", 32'(a_level), 7);
        chk("a full rw overflow", 32'(a_ov), 1);
        chk("a first pop", 32'(a_dout), 1);
        for (int i = 2; i <= 8; i++) begin
            step(0, 0, 0, 1, 8'h00);
            chk("a pop order", 32'(a_dout), 32'(i));
        end
        chk("a empty read_valid", 32'(a_rv), 0);
        step(0, 0, 0, 1, 8'h00);
        chk("a underflow", 32'(a_un), 1);
        step(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 8'(8'h30 + i));
        step(0, 1, 1, 0, 8'h77);
        chk("flush level", 32'(a_level), 0);
        chk("flush read_valid", 32'(b_rv), 0);
        step(0, 0, 1, 0, 8'h55);
        step(0, 0, 0, 1, 8'h00);
        chk("flush word not stored", 32'(a_dout), 32'h055);
        bias = 50;
        for (int c = 0; c < 2000; c++) begin
            if (c % 100 == 0) bias = $urandom_range(15, 85);
            step($urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias - 5, 8'($urandom));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
